// File: rtl/interrupt_pkg.sv
// Shared interrupt definitions: controller FSM states and the instruction
// encodings also used by the CPU's interrupt-injection FSM.
package interrupt_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_INJECT,
    S_SERVICE
  } irq_state_e;

  localparam logic [4:0]  OPC_JUMP   = 5'b10100;
  localparam logic [31:0] INSTR_NOOP = 32'h7800_0000;

  // Jump target wraps within the 27-bit field.
  function automatic logic [31:0] jump_instr(input logic [26:0] base,
                                             input logic [26:0] stride,
                                             input logic [26:0] idx);
    logic [26:0] target;
    target = base + idx * stride;
    return {OPC_JUMP, target};
  endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// Bundle between interrupt sources/CPU (master) and the interrupt controller (slave).
interface interrupt_controller_if #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
);

  logic [NUM_SRC-1:0] irq_in;
  logic [NUM_SRC-1:0] irq_mask;
  logic               ACK;
  logic               int_done;
  logic               INT;
  logic [31:0]        INT_INSTR;
  logic [ID_W-1:0]    active_id;
  logic               in_service;
  logic [NUM_SRC-1:0] pending;

  modport master (
    output irq_in, irq_mask, ACK, int_done,
    input  INT, INT_INSTR, active_id, in_service, pending
  );

  modport slave (
    input  irq_in, irq_mask, ACK, int_done,
    output INT, INT_INSTR, active_id, in_service, pending
  );

endinterface

// File: rtl/irq_pending_reg.sv
// Rising-edge detector with sticky pending bits; a coincident set beats a clear.
module irq_pending_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] irq_i,
  input  logic [WIDTH-1:0] clr_i,
  output logic [WIDTH-1:0] pending_o
);

  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] rise;

  assign rise      = irq_i & ~prev_q;
  // Repeat edges merge into an already-set bit; OR-ing the set last lets it win.
  assign pending_d = (pending_q & ~clr_i) | rise;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values, regardless of the order the always_ff blocks run in.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q    <= '0;
      pending_q <= '0;
    end else begin
      prev_q    <= irq_i;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/interrupt_controller.sv
// Priority interrupt controller: arbitrates pending sources, requests the CPU,
// injects a vectored jump after ACK, then waits for return-from-interrupt.
module interrupt_controller
  import interrupt_pkg::*;
#(
  parameter int          NUM_SRC    = 4,
  parameter logic [26:0] VEC_BASE   = 27'h0002100,
  parameter logic [26:0] VEC_STRIDE = 27'h0000040
) (
  input  logic clk,
  input  logic rst,
  interrupt_controller_if.slave bus
);

  localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  irq_state_e         state_q, state_d;
  logic [ID_W-1:0]    active_id_q, active_id_d;
  logic               int_q;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] pend_clr;
  logic [NUM_SRC-1:0] req_vec;
  logic               req_any;
  logic [ID_W-1:0]    sel_id;

  irq_pending_reg #(.WIDTH(NUM_SRC)) u_pending (
    .clk       (clk),
    .rst       (rst),
    .irq_i     (bus.irq_in),
    .clr_i     (pend_clr),
    .pending_o (pending)
  );

  assign req_vec = pending & bus.irq_mask;
  assign req_any = |req_vec;

  // Scan high to low so the lowest enabled index is the one left standing.
  always_comb begin
    sel_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_vec[i]) sel_id = ID_W'(i);
    end
  end

  always_comb begin
    pend_clr = '0;
    if (state_q == S_REQ && bus.ACK) pend_clr[active_id_q] = 1'b1;
  end

  // NOTE: every always_comb output gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    active_id_d = active_id_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_any) begin
          state_d     = S_REQ;
          active_id_d = sel_id;
        end
      end
      S_REQ:     if (bus.ACK) state_d = S_INJECT;
      S_INJECT:  state_d = S_SERVICE;
      S_SERVICE: if (bus.int_done) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      active_id_q <= '0;
      int_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_id_q <= active_id_d;
      int_q       <= (state_d == S_REQ);
    end
  end

  assign bus.INT        = int_q;
  assign bus.active_id  = active_id_q;
  assign bus.in_service = (state_q == S_INJECT) || (state_q == S_SERVICE);
  assign bus.pending    = pending;
  assign bus.INT_INSTR  = (state_q == S_INJECT)
                          ? jump_instr(VEC_BASE, VEC_STRIDE, 27'(active_id_q))
                          : INSTR_NOOP;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: per-source vector table plus
// hand-written sequences for priority, masking, nesting, set-wins and reset.
module tb_interrupt_controller;

  localparam logic [31:0] NOOP = 32'h7800_0000;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  interrupt_controller_if #(.NUM_SRC(4)) bus ();

  interrupt_controller #(
    .NUM_SRC   (4),
    .VEC_BASE  (27'h0002100),
    .VEC_STRIDE(27'h0000040)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  typedef struct {
    int          src;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_irq(input int src);
    bus.irq_in[src] = 1'b1;
    step();
    bus.irq_in[src] = 1'b0;
  endtask

  task automatic do_ack();
    bus.ACK = 1'b1;
    step();
    bus.ACK = 1'b0;
  endtask

  task automatic do_done();
    bus.int_done = 1'b1;
    step();
    bus.int_done = 1'b0;
  endtask

  initial begin
    vecs[0] = '{0, 32'hA000_2100};
    vecs[1] = '{1, 32'hA000_2140};
    vecs[2] = '{2, 32'hA000_2180};
    vecs[3] = '{3, 32'hA000_21C0};

    rst          = 1'b1;
    bus.irq_in   = '0;
    bus.irq_mask = 4'hF;
    bus.ACK      = 1'b0;
    bus.int_done = 1'b0;
    step(2);
    rst = 1'b0;

    check("rst_int",     32'(bus.INT), 32'd0);
    check("rst_instr",   bus.INT_INSTR, NOOP);
    check("rst_id",      32'(bus.active_id), 32'd0);
    check("rst_insvc",   32'(bus.in_service), 32'd0);
    check("rst_pending", 32'(bus.pending), 32'd0);

    // Single-source flow for each source.
    for (int v = 0; v < 4; v++) begin
      pulse_irq(vecs[v].src);
      check("vec_pend_set", 32'(bus.pending), 32'(1 << vecs[v].src));
      check("vec_int_early", 32'(bus.INT), 32'd0);
      step();
      check("vec_int",  32'(bus.INT), 32'd1);
      check("vec_id",   32'(bus.active_id), 32'(vecs[v].src));
      check("vec_req_instr", bus.INT_INSTR, NOOP);
      do_ack();
      check("vec_instr", bus.INT_INSTR, vecs[v].exp_instr);
      check("vec_insvc_inj", 32'(bus.in_service), 32'd1);
      check("vec_int_inj", 32'(bus.INT), 32'd0);
      check("vec_pend_clr", 32'(bus.pending), 32'd0);
      step();
      check("vec_instr_svc", bus.INT_INSTR, NOOP);
      check("vec_insvc_svc", 32'(bus.in_service), 32'd1);
      do_done();
      check("vec_insvc_idle", 32'(bus.in_service), 32'd0);
      check("vec_int_idle", 32'(bus.INT), 32'd0);
    end

    // Priority: sources 3 and 1 together; 1 first, then 3.
    bus.irq_in = 4'b1010;
    step();
    bus.irq_in = '0;
    step();
    check("prio_int", 32'(bus.INT), 32'd1);
    check("prio_id",  32'(bus.active_id), 32'd1);
    do_ack();
    check("prio_instr1", bus.INT_INSTR, 32'hA000_2140);
    check("prio_pend",   32'(bus.pending), 32'b1000);
    step();
    check("prio_no_int_svc", 32'(bus.INT), 32'd0);
    do_done();
    step();
    check("prio_int2", 32'(bus.INT), 32'd1);
    check("prio_id2",  32'(bus.active_id), 32'd3);
    do_ack();
    check("prio_instr2", bus.INT_INSTR, 32'hA000_21C0);
    step();
    do_done();

    // Masking: masked source still latches; unmask raises INT; re-mask in REQ keeps it.
    bus.irq_mask = 4'b1110;
    pulse_irq(0);
    step(2);
    check("mask_no_int", 32'(bus.INT), 32'd0);
    check("mask_pend",   32'(bus.pending), 32'b0001);
    bus.irq_mask = 4'hF;
    step();
    check("unmask_int", 32'(bus.INT), 32'd1);
    check("unmask_id",  32'(bus.active_id), 32'd0);
    bus.irq_mask = 4'b1110;
    step();
    check("remask_int_held", 32'(bus.INT), 32'd1);
    do_ack();
    check("remask_instr", bus.INT_INSTR, 32'hA000_2100);
    bus.irq_mask = 4'hF;
    step();
    do_done();

    // Stray ACK and int_done in IDLE are ignored.
    do_ack();
    check("stray_ack_int",   32'(bus.INT), 32'd0);
    check("stray_ack_insvc", 32'(bus.in_service), 32'd0);
    check("stray_ack_instr", bus.INT_INSTR, NOOP);
    do_done();
    check("stray_done_insvc", 32'(bus.in_service), 32'd0);

    // No nesting: source 0 arrives during SERVICE of source 2.
    pulse_irq(2);
    step();
    do_ack();
    step();
    pulse_irq(0);
    step(2);
    check("nest_int",   32'(bus.INT), 32'd0);
    check("nest_pend",  32'(bus.pending), 32'b0001);
    check("nest_insvc", 32'(bus.in_service), 32'd1);
    check("nest_id",    32'(bus.active_id), 32'd2);
    do_ack();
    check("svc_ack_ignored", 32'(bus.in_service), 32'd1);
    check("svc_ack_instr",   bus.INT_INSTR, NOOP);
    do_done();
    check("nest_after_done_int", 32'(bus.INT), 32'd0);
    step();
    check("nest_second_int", 32'(bus.INT), 32'd1);
    check("nest_second_id",  32'(bus.active_id), 32'd0);
    do_ack();
    step();
    do_done();

    // Set wins: irq_in[1] rises on the ACK edge for source 1.
    pulse_irq(1);
    step();
    check("setwin_req", 32'(bus.INT), 32'd1);
    bus.irq_in[1] = 1'b1;
    do_ack();
    bus.irq_in[1] = 1'b0;
    check("setwin_pend",  32'(bus.pending), 32'b0010);
    check("setwin_instr", bus.INT_INSTR, 32'hA000_2140);
    step();
    check("setwin_no_int", 32'(bus.INT), 32'd0);
    do_done();
    step();
    check("setwin_reint", 32'(bus.INT), 32'd1);
    check("setwin_id",    32'(bus.active_id), 32'd1);
    do_ack();
    step();
    do_done();

    // Merge: two edges while pending give one service only.
    bus.irq_mask = 4'b0111;
    pulse_irq(3);
    step();
    pulse_irq(3);
    check("merge_pend", 32'(bus.pending), 32'b1000);
    bus.irq_mask = 4'hF;
    step();
    do_ack();
    check("merge_pend_clr", 32'(bus.pending), 32'd0);
    step();
    do_done();
    step(2);
    check("merge_no_second", 32'(bus.INT), 32'd0);

    // Reset mid-REQ abandons the interrupt.
    pulse_irq(2);
    step();
    check("rstreq_int_before", 32'(bus.INT), 32'd1);
    bus.irq_mask = 4'b1011;
    pulse_irq(3);
    bus.irq_mask = 4'hF;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstreq_int",   32'(bus.INT), 32'd0);
    check("rstreq_pend",  32'(bus.pending), 32'd0);
    check("rstreq_instr", bus.INT_INSTR, NOOP);
    check("rstreq_id",    32'(bus.active_id), 32'd0);
    check("rstreq_insvc", 32'(bus.in_service), 32'd0);
    step();
    check("rstreq_int_after", 32'(bus.INT), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
